// File: rtl/dcfir_coe_pkg.sv
// Shared widths, sdi field map and FSM states
// for the coefficient update master.
package dcfir_coe_pkg;

  localparam int COE_W      = 10;
  localparam int SDI_W      = 23;
  localparam int ADDR_W     = 7;
  localparam int N_COE      = 6;
  localparam int FIFO_DEPTH = 4;

  localparam int IDX_W = 3;
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;

  localparam int ENTRY_W = ADDR_W + N_COE * COE_W;

  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 16;
  localparam int IDX_MSB  = 15;
  localparam int IDX_LSB  = 13;
  localparam int PAD_MSB  = 12;
  localparam int PAD_LSB  = 10;
  localparam int COE_MSB  = 9;
  localparam int COE_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    LOAD
  } state_e;

  typedef logic [N_COE-1:0][COE_W-1:0] coe_set_t;

  // coe[0..2] = real 0..2, coe[3..5] = imag 0..2
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    coe_set_t          coe;
  } req_entry_t;

  function automatic logic [SDI_W-1:0] make_word(
    input logic [ADDR_W-1:0] addr,
    input logic [IDX_W-1:0]  idx,
    input logic [COE_W-1:0]  coe
  );
    logic [SDI_W-1:0] w;
    w = '0;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[IDX_MSB:IDX_LSB]   = idx;
    w[PAD_MSB:PAD_LSB]   = '0;
    w[COE_MSB:COE_LSB]   = coe;
    return w;
  endfunction

endpackage

// File: rtl/coe_update_master_if.sv
// Request handshake bundle between a requester
// and the coefficient update master.
interface coe_update_master_if;
  import dcfir_coe_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [COE_W-1:0]  req_coe0_real;
  logic [COE_W-1:0]  req_coe1_real;
  logic [COE_W-1:0]  req_coe2_real;
  logic [COE_W-1:0]  req_coe0_imag;
  logic [COE_W-1:0]  req_coe1_imag;
  logic [COE_W-1:0]  req_coe2_imag;

  modport master (
    output req_valid,
    output req_addr,
    output req_coe0_real,
    output req_coe1_real,
    output req_coe2_real,
    output req_coe0_imag,
    output req_coe1_imag,
    output req_coe2_imag,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_coe0_real,
    input  req_coe1_real,
    input  req_coe2_real,
    input  req_coe0_imag,
    input  req_coe1_imag,
    input  req_coe2_imag,
    output req_ready
  );

endinterface

// File: rtl/coe_req_fifo.sv
// Synchronous request FIFO; push is ignored when
// full and pop is ignored when empty.
module coe_req_fifo
  import dcfir_coe_pkg::*;
(
  input  logic             CLK,
  input  logic             rst,
  input  logic             push,
  input  req_entry_t       wdata,
  input  logic             pop,
  output req_entry_t       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = req_entry_t'(mem_q[rd_ptr_q]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case (1'b1)
      do_push && !do_pop: cnt_d = cnt_q + 1'b1;
      do_pop && !do_push: cnt_d = cnt_q - 1'b1;
      default:            cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/coe_update_master.sv
// Serialises queued coefficient sets onto the sdi bus
// and issues one coe_load per pending commit.
module coe_update_master
  import dcfir_coe_pkg::*;
(
  input  logic               CLK,
  input  logic               rst,
  coe_update_master_if.slave req,
  input  logic               commit,
  output logic               ssb,
  output logic [SDI_W-1:0]   sdi,
  output logic               coe_load,
  output logic               busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  req_entry_t       cur_q, cur_d;
  logic             pend_q, pend_d;
  logic             ssb_q, ssb_d;
  logic [SDI_W-1:0] sdi_q, sdi_d;
  logic             load_q, load_d;

  req_entry_t       wdata, head;
  logic             push, pop;
  logic             full, empty;
  logic [CNT_W-1:0] count;

  assign req.req_ready = !full;
  assign push = req.req_valid && !full;

  always_comb begin
    wdata        = '0;
    wdata.addr   = req.req_addr;
    wdata.coe[0] = req.req_coe0_real;
    wdata.coe[1] = req.req_coe1_real;
    wdata.coe[2] = req.req_coe2_real;
    wdata.coe[3] = req.req_coe0_imag;
    wdata.coe[4] = req.req_coe1_imag;
    wdata.coe[5] = req.req_coe2_imag;
  end

  coe_req_fifo u_fifo (
    .CLK   (CLK),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Each state computes the registered outputs
  // shown during the following cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    pend_d  = pend_q || commit;
    ssb_d   = 1'b1;
    sdi_d   = '0;
    load_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          ssb_d   = 1'b0;
          sdi_d   = make_word(head.addr, '0,
                              head.coe[0]);
          idx_d   = IDX_W'(1);
          state_d = SEND;
        end else if (pend_q) begin
          state_d = LOAD;
        end
      end
      SEND: begin
        ssb_d = 1'b0;
        sdi_d = make_word(cur_q.addr, idx_q,
                          cur_q.coe[idx_q]);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_COE - 1)) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      LOAD: begin
        load_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
      ssb_q   <= 1'b1;
      sdi_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      ssb_q   <= ssb_d;
      sdi_q   <= sdi_d;
      load_q  <= load_d;
    end
  end

  assign ssb      = ssb_q;
  assign sdi      = sdi_q;
  assign coe_load = load_q;
  assign busy     = (count != '0) || (state_q != IDLE)
                 || pend_q || !ssb_q || load_q;

endmodule

// File: tb/tb_coe_update_master.sv
// Directed bench for coe_update_master: frame
// format, commit ordering, overflow and reset.
module tb_coe_update_master;
  import dcfir_coe_pkg::*;

  logic             CLK = 1'b0;
  logic             rst;
  logic             commit;
  logic             ssb;
  logic [SDI_W-1:0] sdi;
  logic             coe_load;
  logic             busy;

  coe_update_master_if bus();

  coe_update_master dut (
    .CLK      (CLK),
    .rst      (rst),
    .req      (bus),
    .commit   (commit),
    .ssb      (ssb),
    .sdi      (sdi),
    .coe_load (coe_load),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lo_run = 0;
  int hi_run = 0;
  int n_loads = 0;
  int last_lo = 0;
  int last_load = 0;
  logic prev_ssb = 1'b1;
  logic [SDI_W-1:0] got_q [$];
  logic [SDI_W-1:0] exp_q [$];
  int len_q [$];
  int gap_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log the bus.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (ssb === 1'b1) chk("idle_sdi", 32'(sdi), 0);
    if (ssb === 1'b0) chk("load_in_frame", 32'(coe_load), 0);
    if (coe_load === 1'b1) begin
      n_loads++;
      last_load = cyc;
    end
    if (ssb === 1'b0) begin
      got_q.push_back(sdi);
      if (prev_ssb) gap_q.push_back(hi_run);
      lo_run++;
      hi_run = 0;
      last_lo = cyc;
    end else begin
      if (!prev_ssb) len_q.push_back(lo_run);
      lo_run = 0;
      hi_run++;
    end
    prev_ssb = ssb;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    len_q.delete();
    gap_q.delete();
    n_loads = 0;
  endtask

  task automatic drive(input logic [6:0] a,
                       input logic [5:0][9:0] c);
    bus.req_valid     = 1'b1;
    bus.req_addr      = a;
    bus.req_coe0_real = c[0];
    bus.req_coe1_real = c[1];
    bus.req_coe2_real = c[2];
    bus.req_coe0_imag = c[3];
    bus.req_coe1_imag = c[4];
    bus.req_coe2_imag = c[5];
  endtask

  task automatic add_exp(input logic [6:0] a,
                         input logic [5:0][9:0] c);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({a, 3'(k), 3'b000, c[k]});
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy), 0);
    repeat (3) tick();
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nwords"}, 32'(got_q.size()),
        32'(exp_q.size()));
    for (int i = 0; i < got_q.size()
         && i < exp_q.size(); i++) begin
      chk({tag, "_word"}, 32'(got_q[i]),
          32'(exp_q[i]));
    end
    foreach (len_q[i]) chk({tag, "_len"}, 32'(len_q[i]), 6);
    for (int i = 1; i < gap_q.size(); i++) begin
      chk({tag, "_gap"}, 32'(gap_q[i]), 1);
    end
  endtask

  initial begin
    logic [5:0][9:0] c;
    int nw;
    int n;

    rst = 1'b1;
    commit = 1'b0;
    bus.req_valid = 1'b0;
    drive(7'h00, '0);
    bus.req_valid = 1'b0;

    // reset values, during and after reset
    tick();
    tick();
    chk("rst_ssb", 32'(ssb), 1);
    chk("rst_sdi", 32'(sdi), 0);
    chk("rst_load", 32'(coe_load), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.req_ready), 1);
    rst = 1'b0;
    tick();
    chk("post_ssb", 32'(ssb), 1);
    chk("post_sdi", 32'(sdi), 0);
    chk("post_load", 32'(coe_load), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_ready", 32'(bus.req_ready), 1);

    // single request, commit 20 cycles later
    clear_mon();
    c = {10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
    drive(7'h05, c);
    chk("t2_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    exp_q.push_back(23'h050001);
    exp_q.push_back(23'h052002);
    exp_q.push_back(23'h054003);
    exp_q.push_back(23'h056004);
    exp_q.push_back(23'h058005);
    exp_q.push_back(23'h05A006);
    repeat (19) tick();
    chk("t2_noload_yet", 32'(n_loads), 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    run_idle(60);
    check_frames("t2");
    chk("t2_nframes", 32'(len_q.size()), 1);
    chk("t2_loads", 32'(n_loads), 1);

    // request and commit in the same cycle
    clear_mon();
    c = {10'h3ff, 10'h200, 10'h155,
         10'h0aa, 10'h001, 10'h000};
    drive(7'h7f, c);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    bus.req_valid = 1'b0;
    add_exp(7'h7f, c);
    run_idle(60);
    check_frames("t3");
    chk("t3_loads", 32'(n_loads), 1);
    chk("t3_load_after_gap",
        32'(last_load >= last_lo + 2), 1);

    // six requests back to back; the sixth is refused
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 6; k++) begin
        c[k] = 10'(i * 16 + k + 1);
      end
      drive(7'(8'h10 + i), c);
      chk("t4_ready", 32'(bus.req_ready), 32'(i < 5));
      if (i < 5) add_exp(7'(8'h10 + i), c);
      tick();
    end
    bus.req_valid = 1'b0;
    run_idle(200);
    check_frames("t4");
    chk("t4_nframes", 32'(len_q.size()), 5);
    chk("t4_loads", 32'(n_loads), 0);

    // two commits while two frames are queued
    clear_mon();
    c = {10'd60, 10'd50, 10'd40, 10'd30, 10'd20, 10'd10};
    drive(7'h21, c);
    add_exp(7'h21, c);
    tick();
    c = {10'd66, 10'd55, 10'd44, 10'd33, 10'd22, 10'd11};
    drive(7'h22, c);
    add_exp(7'h22, c);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    run_idle(80);
    check_frames("t5");
    chk("t5_nframes", 32'(len_q.size()), 2);
    chk("t5_loads", 32'(n_loads), 1);
    chk("t5_load_after_gap",
        32'(last_load >= last_lo + 2), 1);

    // reset asserted while word index 3 is on the bus
    clear_mon();
    c = {10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4};
    drive(7'h33, c);
    tick();
    drive(7'h34, c);
    tick();
    bus.req_valid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n = 0;
    while (got_q.size() < 4 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_word3", 32'(sdi), 32'({7'h33, 3'd3, 3'b000, 10'd7}));
    rst = 1'b1;
    tick();
    chk("t6_ssb", 32'(ssb), 1);
    chk("t6_sdi", 32'(sdi), 0);
    chk("t6_load", 32'(coe_load), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(bus.req_ready), 1);
    rst = 1'b0;
    tick();
    chk("t6_post_ssb", 32'(ssb), 1);
    chk("t6_post_busy", 32'(busy), 0);
    nw = got_q.size();
    repeat (20) tick();
    chk("t6_no_resume", 32'(got_q.size()), 32'(nw));
    chk("t6_loads", 32'(n_loads), 0);
    chk("t6_idle_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
